regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the multi-cycle and pipelined MIPS datapaths.
//  - NUM_RD read ports, two write ports: port 0 for ALU writeback, port 1 for memory writeback.
//  - Optional hard-wired zero register and write-to-read bypass.
//  - Optional registered read.
//  - Per-register busy scoreboard that the control unit uses to stall on pending writes.
// PARAMETERS
//  DW        32  data width in bits
//  DEPTH     32  number of registers; power of 2
//  AW        5   address width; equals log2(DEPTH)
//  NUM_RD    2   number of read ports, 1..4
//  ZERO_REG  1   1: register 0 always reads 0; writes to it and busy-sets on it are ignored
//  BYPASS    1   1: a write to the same address in the same cycle is forwarded to rd_data
//  RD_LAT    0   0: combinational read; 1: rd_data is registered, 1 cycle latency
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          asynchronous reset, active-high
//  rd_addr   in   NUM_RD*AW  read addresses; port i is bits [i*AW +: AW]
//  rd_data   out  NUM_RD*DW  read data; port i is bits [i*DW +: DW]
//  rd_busy   out  NUM_RD     busy bit of the register rd_addr[i] selects (same latency as rd_data)
//  we0       in   1          write enable, port 0
//  waddr0    in   AW         write address, port 0
//  wdata0    in   DW         write data, port 0
//  we1       in   1          write enable, port 1
//  waddr1    in   AW         write address, port 1
//  wdata1    in   DW         write data, port 1
//  bset      in   1          mark register baddr busy (an instruction that writes it has issued)
//  baddr     in   AW         address for bset
//  busy_any  out  1          OR of all busy bits
// BEHAVIOUR
//  - Reset, asynchronous: all registers = 0; all busy bits = 0; registered rd_data/rd_busy = 0
//    when RD_LAT=1. Reset asserted mid-operation aborts any write in flight; nothing is committed.
//  - Write: on the posedge, if weN and the address is valid, reg[waddrN] <= wdataN.
//    A write to address 0 is dropped when ZERO_REG=1.
//  - Write collision (we0 & we1 & waddr0==waddr1): port 1 wins. The busy bit for that address is
//    cleared once.
//  - Read, RD_LAT=0: rd_data[i] = reg[rd_addr[i]] combinationally.
//    With BYPASS=1, a same-cycle write to that address is forwarded (port 1 over port 0).
//    Address 0 with ZERO_REG=1 reads 0, and bypass does not apply.
//  - Read, RD_LAT=1: the same value is sampled at the posedge; it appears the cycle after the address.
//    With BYPASS=1, the sampled value includes a write at that same edge.
//    With BYPASS=0, it is the pre-write value.
//  - Scoreboard: busy[a] is set at the posedge when bset & baddr==a, unless a==0 and ZERO_REG=1.
//    busy[a] is cleared at the posedge by any committed write to a.
//    Simultaneous set and clear on the same address: the set wins, because a newer producer has issued.
//  - rd_busy[i]: busy[rd_addr[i]] is the current state. It does not reflect same-cycle set or clear.
//  - busy_any: OR of the registered busy bits; no combinational path from the inputs.
//  - Any read port may alias any other read port or either write port; ports are independent.
//  - Widths: no arithmetic; addresses are used modulo DEPTH, so out-of-range values cannot occur.
// STRUCTURE
//  - Shared include regfile_defs.vh: default DW/DEPTH/AW and the ZERO_ADDR constant.
//    Used by the datapath and the control unit.
//  - Sub-module regfile_scoreboard (DEPTH, AW, ZERO_REG): owns the busy vector, the set/clear
//    priority and busy_any. The top level instantiates it once and indexes it per read port.
//  - Top level: register array, write priority mux, a generate loop over the NUM_RD read ports
//    (bypass mux plus optional output register).
// TESTING
//  1. Reset after a random fill -> all rd_data=0, rd_busy=0, busy_any=0, with no clock edge needed.
//  2. we0 waddr0=5 wdata0=32'hDEADBEEF; next cycle rd_addr[0]=5 -> 32'hDEADBEEF.
//     Same-cycle read with BYPASS=1 -> 32'hDEADBEEF. With BYPASS=0 -> old value.
//  3. we0 and we1 both to address 7, data 32'h11 and 32'h22 -> register 7 reads 32'h22 afterwards.
//  4. ZERO_REG=1: we0 waddr0=0 wdata0=32'hFFFFFFFF, plus bset baddr=0 -> register 0 reads 0, busy_any=0.
//  5. bset baddr=9 -> rd_busy=1 and busy_any=1.
//     Then bset 9 together with we1 waddr1=9 -> busy stays 1. A later lone write to 9 -> busy 0.
//  6. RD_LAT=1, NUM_RD=4, four distinct addresses -> each rd_data matches one cycle later.
//     rst pulsed between edges -> outputs go to 0 immediately.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default geometry and the
// address of the hard-wired zero register. Used by the datapath and control unit.
package regfile_mp_pkg;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDepth = 32;
  localparam int unsigned DefAw    = 5;
  localparam int unsigned ZeroAddr = 0;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   set_i, set_addr_i     mark a register busy (a producer has issued)
//   clr0_i/clr0_addr_i    committed write on port 0 clears busy
//   clr1_i/clr1_addr_i    committed write on port 1 clears busy
//   busy_o                registered busy vector, one bit per register
//   busy_any_o            OR of the registered busy bits
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AW       = DefAw,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr0_i,
  input  logic [AW-1:0]    clr0_addr_i,
  input  logic             clr1_i,
  input  logic [AW-1:0]    clr1_addr_i,
  output logic [DEPTH-1:0] busy_o,
  output logic             busy_any_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_i) set_vec[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) set_vec[ZeroAddr] = 1'b0;
    if (clr0_i) clr_vec[clr0_addr_i] = 1'b1;
    if (clr1_i) clr_vec[clr1_addr_i] = 1'b1;
    // Set wins over clear: a newer producer has issued for that register.
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign busy_any_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rd_addr_i  NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data_o  NUM_RD*DW    read data, port i at [i*DW +: DW]
//   rd_busy_o  NUM_RD       busy bit of the addressed register (same latency as data)
//   we0_i/waddr0_i/wdata0_i write port 0 (ALU writeback)
//   we1_i/waddr1_i/wdata1_i write port 1 (memory writeback), wins on collision
//   bset_i/baddr_i          mark register busy
//   busy_any_o              OR of all busy bits
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW       = DefDw,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AW       = DefAw,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_LAT   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD*DW-1:0] rd_data_o,
  output logic [NUM_RD-1:0]    rd_busy_o,
  input  logic                 we0_i,
  input  logic [AW-1:0]        waddr0_i,
  input  logic [DW-1:0]        wdata0_i,
  input  logic                 we1_i,
  input  logic [AW-1:0]        waddr1_i,
  input  logic [DW-1:0]        wdata1_i,
  input  logic                 bset_i,
  input  logic [AW-1:0]        baddr_i,
  output logic                 busy_any_o
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             we0_ok, we1_ok;

  // Writes to the zero register are dropped and therefore neither commit nor clear busy.
  assign we0_ok = we0_i & ~((ZERO_REG != 0) & (waddr0_i == AW'(ZeroAddr)));
  assign we1_ok = we1_i & ~((ZERO_REG != 0) & (waddr1_i == AW'(ZeroAddr)));

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (we0_ok) mem_d[waddr0_i] = wdata0_i;
    if (we1_ok) mem_d[waddr1_i] = wdata1_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  regfile_mp_scoreboard #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (bset_i),
    .set_addr_i (baddr_i),
    .clr0_i     (we0_ok),
    .clr0_addr_i(waddr0_i),
    .clr1_i     (we1_ok),
    .clr1_addr_i(waddr1_i),
    .busy_o     (busy),
    .busy_any_o (busy_any_o)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    assign raddr = rd_addr_i[g*AW +: AW];

    // This value is also what the registered read samples, so with bypass it
    // already holds the write landing on the same edge.
    always_comb begin
      rdata = mem_q[raddr];
      if (BYPASS != 0) begin
        if (we0_ok && (waddr0_i == raddr)) rdata = wdata0_i;
        if (we1_ok && (waddr1_i == raddr)) rdata = wdata1_i;
      end
      if ((ZERO_REG != 0) && (raddr == AW'(ZeroAddr))) rdata = '0;
    end

    if (RD_LAT != 0) begin : g_reg
      logic [DW-1:0] rdata_q;
      logic          rbusy_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rdata_q <= '0;
          rbusy_q <= 1'b0;
        end else begin
          rdata_q <= rdata;
          rbusy_q <= busy[raddr];
        end
      end

      assign rd_data_o[g*DW +: DW] = rdata_q;
      assign rd_busy_o[g]          = rbusy_q;
    end else begin : g_comb
      assign rd_data_o[g*DW +: DW] = rdata;
      assign rd_busy_o[g]          = busy[raddr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we0, we1, bset;
  logic [4:0]  waddr0, waddr1, baddr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  ra_a, ra_b;
  logic [19:0] ra_c;
  logic [63:0] rd_a, rd_b;
  logic [127:0] rd_c;
  logic [1:0]  rb_a, rb_b;
  logic [3:0]  rb_c;
  logic        any_a, any_b, any_c;

  // Reference model: register contents, busy bits, and the values the
  // registered-read instance should present after the most recent edge.
  logic [31:0] mdl [32];
  logic [31:0] mbusy;
  logic [31:0] expc_data [4];
  logic        expc_busy [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Default configuration: bypass, combinational read.
  regfile_mp #(.NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .RD_LAT(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(ra_a), .rd_data_o(rd_a), .rd_busy_o(rb_a),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .bset_i(bset), .baddr_i(baddr), .busy_any_o(any_a)
  );

  // No bypass, combinational read.
  regfile_mp #(.NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .RD_LAT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(ra_b), .rd_data_o(rd_b), .rd_busy_o(rb_b),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .bset_i(bset), .baddr_i(baddr), .busy_any_o(any_b)
  );

  // Four read ports, registered read, bypass.
  regfile_mp #(.NUM_RD(4), .ZERO_REG(1), .BYPASS(1), .RD_LAT(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(ra_c), .rd_data_o(rd_c), .rd_busy_o(rb_c),
    .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .bset_i(bset), .baddr_i(baddr), .busy_any_o(any_c)
  );

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
    waddr0 = '0; waddr1 = '0; baddr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mbusy = '0;
    for (int i = 0; i < 4; i++) begin
      expc_data[i] = '0;
      expc_busy[i] = 1'b0;
    end
  endtask

  // Expected same-cycle read for a combinational port.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return '0;
    if (byp && we1 && waddr1 == a) return wdata1;
    if (byp && we0 && waddr0 == a) return wdata0;
    return mdl[a];
  endfunction

  // Advance one clock edge and apply the commit rules to the model.
  task automatic cycle();
    logic pre [4];
    for (int i = 0; i < 4; i++) pre[i] = mbusy[ra_c[i*5 +: 5]];
    @(posedge clk);
    if (!rst) begin
      if (we0 && waddr0 != 5'd0) begin mdl[waddr0] = wdata0; mbusy[waddr0] = 1'b0; end
      if (we1 && waddr1 != 5'd0) begin mdl[waddr1] = wdata1; mbusy[waddr1] = 1'b0; end
      if (bset && baddr != 5'd0) mbusy[baddr] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        expc_data[i] = mdl[ra_c[i*5 +: 5]];
        expc_busy[i] = pre[i];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 20; k++) begin
      we0 = 1'($urandom); waddr0 = 5'($urandom); wdata0 = $urandom;
      we1 = 1'($urandom); waddr1 = 5'($urandom); wdata1 = $urandom;
      bset = 1'($urandom); baddr = 5'($urandom);
      ra_a = 10'($urandom); ra_b = 10'($urandom); ra_c = 20'($urandom);
      cycle();
    end
    bset = 1'b1; baddr = 5'd9;
    cycle();
    idle();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (rd_a !== '0) begin n_fail++; $display("FAIL reset_rd_a: got %h want 0", rd_a); end
    n_checks++;
    if (rd_b !== '0) begin n_fail++; $display("FAIL reset_rd_b: got %h want 0", rd_b); end
    n_checks++;
    if (rd_c !== '0) begin n_fail++; $display("FAIL reset_rd_c: got %h want 0", rd_c); end
    n_checks++;
    if ({rb_a, rb_b, rb_c} !== '0) begin
      n_fail++; $display("FAIL reset_rd_busy: got %b want 0", {rb_a, rb_b, rb_c});
    end
    n_checks++;
    if ({any_a, any_b, any_c} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy_any: got %b want 000", {any_a, any_b, any_c});
    end
    // A write held across an edge while in reset must not commit.
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = $urandom | 32'h1;
    ra_a = {5'd3, 5'd3};
    cycle();
    idle();
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (rd_a[31:0] !== '0) begin
      n_fail++; $display("FAIL reset_abort_write: got %h want 0", rd_a[31:0]);
    end
  endtask

  task automatic test_write_read();
    idle();
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0BAD_F00D;
    cycle();
    idle();
    ra_a[4:0] = 5'd5; ra_b[4:0] = 5'd5; ra_c[4:0] = 5'd5;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_bypass_same_cycle: got %h want deadbeef", rd_a[31:0]);
    end
    n_checks++;
    if (rd_b[31:0] !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL wr_nobypass_old: got %h want 0badf00d", rd_b[31:0]);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_read_next_a: got %h want deadbeef", rd_a[31:0]);
    end
    n_checks++;
    if (rd_b[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_read_next_b: got %h want deadbeef", rd_b[31:0]);
    end
    n_checks++;
    if (rd_c[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_reglat_bypass: got %h want deadbeef", rd_c[31:0]);
    end
  endtask

  task automatic test_collision();
    idle();
    bset = 1'b1; baddr = 5'd7;
    cycle();
    idle();
    ra_a[4:0] = 5'd7; ra_b[4:0] = 5'd7;
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b1) begin n_fail++; $display("FAIL coll_busy_set: got %b want 1", rb_a[0]); end
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h22) begin
      n_fail++; $display("FAIL coll_bypass_port1: got %h want 22", rd_a[31:0]);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (rd_a[31:0] !== 32'h22) begin
      n_fail++; $display("FAIL coll_port1_wins_a: got %h want 22", rd_a[31:0]);
    end
    n_checks++;
    if (rd_b[31:0] !== 32'h22) begin
      n_fail++; $display("FAIL coll_port1_wins_b: got %h want 22", rd_b[31:0]);
    end
    n_checks++;
    if (rb_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL coll_busy_clear: got %b want 0", rb_a[0]);
    end
  endtask

  task automatic test_zero();
    idle();
    ra_a = {5'd0, 5'd0}; ra_b[4:0] = 5'd0;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    bset = 1'b1; baddr = 5'd0;
    #1;
    n_checks++;
    if (rd_a[31:0] !== '0) begin
      n_fail++; $display("FAIL zero_no_bypass: got %h want 0", rd_a[31:0]);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (rd_a !== '0) begin n_fail++; $display("FAIL zero_read_a: got %h want 0", rd_a); end
    n_checks++;
    if (rd_b[31:0] !== '0) begin n_fail++; $display("FAIL zero_read_b: got %h want 0", rd_b[31:0]); end
    n_checks++;
    if (any_a !== 1'b0 || rb_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: got any=%b rb=%b want 0 0", any_a, rb_a[0]);
    end
  endtask

  task automatic test_busy();
    idle();
    ra_a[4:0] = 5'd9;
    bset = 1'b1; baddr = 5'd9;
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_not_same_cycle: got %b want 0", rb_a[0]);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b1 || any_a !== 1'b1) begin
      n_fail++; $display("FAIL busy_set: got rb=%b any=%b want 1 1", rb_a[0], any_a);
    end
    bset = 1'b1; baddr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    cycle();
    idle();
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_set_beats_clear: got %b want 1", rb_a[0]);
    end
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h5;
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_clear_not_same_cycle: got %b want 1", rb_a[0]);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (rb_a[0] !== 1'b0 || any_a !== 1'b0 || any_c !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_cleared: got rb=%b any_a=%b any_c=%b want 0 0 0", rb_a[0], any_a, any_c);
    end
  endtask

  task automatic test_reglat();
    idle();
    for (int i = 0; i < 4; i++) begin
      we0 = 1'b1; waddr0 = 5'(12 + i); wdata0 = 32'hC0DE_0000 + 32'(i);
      cycle();
    end
    idle();
    ra_c = {5'd15, 5'd14, 5'd13, 5'd12};
    cycle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_c[i*32 +: 32] !== 32'hC0DE_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL reglat_port%0d: got %h want %h", i, rd_c[i*32 +: 32],
                 32'hC0DE_0000 + 32'(i));
      end
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (rd_c !== '0 || rb_c !== '0) begin
      n_fail++; $display("FAIL reglat_async_reset: got %h/%b want 0/0", rd_c, rb_c);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [4:0]  a;
    logic [31:0] exp;
    for (int k = 0; k < n; k++) begin
      we0 = 1'($urandom); waddr0 = 5'($urandom_range(0, 15)); wdata0 = $urandom;
      we1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 15)); wdata1 = $urandom;
      bset = ($urandom_range(0, 3) == 0); baddr = 5'($urandom_range(0, 15));
      for (int i = 0; i < 2; i++) begin
        ra_a[i*5 +: 5] = 5'($urandom_range(0, 15));
        ra_b[i*5 +: 5] = 5'($urandom_range(0, 15));
      end
      for (int i = 0; i < 4; i++) ra_c[i*5 +: 5] = 5'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 2; i++) begin
        a = ra_a[i*5 +: 5];
        exp = model_read(a, 1'b1);
        n_checks++;
        if (rd_a[i*32 +: 32] !== exp || rb_a[i] !== mbusy[a]) begin
          n_fail++;
          $display("FAIL rand_a port%0d addr %0d: got %h/%b want %h/%b", i, a,
                   rd_a[i*32 +: 32], rb_a[i], exp, mbusy[a]);
        end
        a = ra_b[i*5 +: 5];
        exp = model_read(a, 1'b0);
        n_checks++;
        if (rd_b[i*32 +: 32] !== exp || rb_b[i] !== mbusy[a]) begin
          n_fail++;
          $display("FAIL rand_b port%0d addr %0d: got %h/%b want %h/%b", i, a,
                   rd_b[i*32 +: 32], rb_b[i], exp, mbusy[a]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd_c[i*32 +: 32] !== expc_data[i] || rb_c[i] !== expc_busy[i]) begin
          n_fail++;
          $display("FAIL rand_c port%0d: got %h/%b want %h/%b", i, rd_c[i*32 +: 32], rb_c[i],
                   expc_data[i], expc_busy[i]);
        end
      end
      n_checks++;
      if (any_a !== (|mbusy) || any_b !== (|mbusy) || any_c !== (|mbusy)) begin
        n_fail++;
        $display("FAIL rand_busy_any: got %b%b%b want %b", any_a, any_b, any_c, |mbusy);
      end
      cycle();
    end
  endtask

  initial begin
    idle();
    ra_a = '0; ra_b = '0; ra_c = '0;
    model_reset();
    #2 rst = 1'b1;
    #6 rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_collision();
    test_zero();
    test_busy();
    test_reglat();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
